// File: rtl/fmap_pkg.sv
// Shared types and default widths for the feature-map write address path.
// Imported by the index counter and by the top level.
package fmap_pkg;

  localparam int FMAP_ADDR_W = 10;
  localparam int FMAP_DATA_W = 8;
  localparam int FMAP_DIM_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } fmap_state_t;

endpackage

// File: rtl/fmap_wr_index_counter.sv
// Nested col/row counter with a row_base accumulator.
// Produces the row-major write address for the current pixel.
module fmap_wr_index_counter
  import fmap_pkg::*;
#(
  parameter int ADDR_W = FMAP_ADDR_W,
  parameter int DIM_W  = FMAP_DIM_W
) (
  input  logic              FMAP_IDX_Clk,
  input  logic              FMAP_IDX_Clr,
  input  logic              load,
  input  logic              fire,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [DIM_W-1:0]  cols,
  input  logic [DIM_W-1:0]  rows,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0]  col;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  cols_q;
  logic [DIM_W-1:0]  rows_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_base;
  logic              col_wrap;
  logic              row_wrap;

  assign col_wrap = (col == cols_q - DIM_W'(1));
  assign row_wrap = (row == rows_q - DIM_W'(1));
  assign last     = col_wrap & row_wrap;
  assign addr     = row_base + ADDR_W'(col);

  always_ff @(posedge FMAP_IDX_Clk or negedge FMAP_IDX_Clr) begin
    if (!FMAP_IDX_Clr) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      stride_q <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      row_base <= base;
      cols_q   <= cols;
      rows_q   <= rows;
      stride_q <= stride;
    end else if (fire) begin
      if (col_wrap) begin
        col      <= '0;
        row      <= row + DIM_W'(1);
        row_base <= row_base + stride_q;
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_write_addr_gen.sv
// Feature-map write address generator: accepts result pixels and
// writes a Rows x Cols tile row-major into a single-port memory.
module fmap_write_addr_gen
  import fmap_pkg::*;
#(
  parameter int ADDR_W = FMAP_ADDR_W,
  parameter int DATA_W = FMAP_DATA_W,
  parameter int DIM_W  = FMAP_DIM_W
) (
  input  logic              FMAP_WR_Clk,
  input  logic              FMAP_WR_Clr,
  input  logic              FMAP_WR_Start,
  input  logic [ADDR_W-1:0] FMAP_WR_Base,
  input  logic [DIM_W-1:0]  FMAP_WR_Cols,
  input  logic [DIM_W-1:0]  FMAP_WR_Rows,
  input  logic [ADDR_W-1:0] FMAP_WR_Stride,
  input  logic              FMAP_WR_In_Valid,
  input  logic [DATA_W-1:0] FMAP_WR_In_Data,
  output logic              FMAP_WR_In_Ready,
  output logic              FMAP_WR_Mem_We,
  output logic [ADDR_W-1:0] FMAP_WR_Mem_Addr,
  output logic [DATA_W-1:0] FMAP_WR_Mem_Data,
  output logic              FMAP_WR_Busy,
  output logic              FMAP_WR_Done
);

  fmap_state_t       state_q;
  fmap_state_t       state_d;
  logic              load;
  logic              fire;
  logic              last;
  logic [ADDR_W-1:0] addr;

  assign FMAP_WR_In_Ready = (state_q == ST_WRITE);
  assign FMAP_WR_Busy     = (state_q == ST_WRITE);
  // DONE lasts one cycle, which lines up with the final registered write
  assign FMAP_WR_Done     = (state_q == ST_DONE);
  assign fire = FMAP_WR_In_Valid & FMAP_WR_In_Ready;

  fmap_wr_index_counter #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_idx (
    .FMAP_IDX_Clk (FMAP_WR_Clk),
    .FMAP_IDX_Clr (FMAP_WR_Clr),
    .load         (load),
    .fire         (fire),
    .base         (FMAP_WR_Base),
    .stride       (FMAP_WR_Stride),
    .cols         (FMAP_WR_Cols),
    .rows         (FMAP_WR_Rows),
    .addr         (addr),
    .last         (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (FMAP_WR_Start) begin
          load = 1'b1;
          if (FMAP_WR_Cols == '0 || FMAP_WR_Rows == '0)
            state_d = ST_DONE;
          else
            state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (fire && last)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FMAP_WR_Clk or negedge FMAP_WR_Clr) begin
    if (!FMAP_WR_Clr) begin
      state_q          <= ST_IDLE;
      FMAP_WR_Mem_We   <= 1'b0;
      FMAP_WR_Mem_Addr <= '0;
      FMAP_WR_Mem_Data <= '0;
    end else begin
      state_q        <= state_d;
      FMAP_WR_Mem_We <= fire;
      if (fire) begin
        FMAP_WR_Mem_Addr <= addr;
        FMAP_WR_Mem_Data <= FMAP_WR_In_Data;
      end
    end
  end

endmodule

// File: tb/tb_fmap_write_addr_gen.sv
// Scoreboard bench for fmap_write_addr_gen: stimulus pushes expected
// memory writes, a negedge monitor pops and compares them.
module tb_fmap_write_addr_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] base;
  logic [5:0] cols;
  logic [5:0] rows;
  logic [9:0] stride;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;

  typedef struct {
    bit       we;
    bit [9:0] addr;
    bit [7:0] data;
    bit       dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  fmap_write_addr_gen dut (
    .FMAP_WR_Clk      (clk),
    .FMAP_WR_Clr      (rst_n),
    .FMAP_WR_Start    (start),
    .FMAP_WR_Base     (base),
    .FMAP_WR_Cols     (cols),
    .FMAP_WR_Rows     (rows),
    .FMAP_WR_Stride   (stride),
    .FMAP_WR_In_Valid (in_valid),
    .FMAP_WR_In_Data  (in_data),
    .FMAP_WR_In_Ready (in_ready),
    .FMAP_WR_Mem_We   (mem_we),
    .FMAP_WR_Mem_Addr (mem_addr),
    .FMAP_WR_Mem_Data (mem_data),
    .FMAP_WR_Busy     (busy),
    .FMAP_WR_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // monitor: every write or done pulse must match the next expectation
  always @(negedge clk) begin
    if (rst_n && (mem_we || done)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", {30'd0, mem_we, done}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mem_we", int'(mem_we), int'(e.we));
        if (e.we) begin
          chk("mem_addr", int'(mem_addr), int'(e.addr));
          chk("mem_data", int'(mem_data), int'(e.data));
        end
        chk("done", int'(done), int'(e.dn));
      end
    end
  end

  task automatic push(input bit we, input bit [9:0] a,
                      input bit [7:0] d, input bit dn);
    exp_t e;
    e.we = we; e.addr = a; e.data = d; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic do_start(input bit [9:0] b, input bit [9:0] s,
                          input bit [5:0] r, input bit [5:0] c);
    @(negedge clk);
    start = 1'b1; base = b; stride = s; rows = r; cols = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // present one pixel; it fires on the posedge after In_Ready is seen
  task automatic send(input bit [7:0] d, input bit [9:0] a, input bit dn);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    else push(1'b1, a, d, dn);
    @(posedge clk);
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_left", q.size(), 0);
  endtask

  bit [9:0] t1_addr [6];
  bit [9:0] wrap_addr [6];

  initial begin
    t1_addr   = '{10'd100, 10'd101, 10'd102, 10'd108, 10'd109, 10'd110};
    wrap_addr = '{10'd1020, 10'd1021, 10'd1022, 10'd1023, 10'd0, 10'd1};
    rst_n = 1'b0; start = 1'b0; base = '0; cols = '0; rows = '0;
    stride = '0; in_valid = 1'b0; in_data = '0;
    #12;
    chk("rst_we", int'(mem_we), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_data", int'(mem_data), 0);
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2x3 tile, valid held high
    do_start(10'd100, 10'd8, 6'd2, 6'd3);
    for (int i = 0; i < 6; i++)
      send(8'(8'h10 + i), t1_addr[i], i == 5);
    bubble();
    drain();
    chk("busy_after_t1", int'(busy), 0);

    // same tile with bubbles between pixels
    do_start(10'd100, 10'd8, 6'd2, 6'd3);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h20 + i), t1_addr[i], i == 5);
      bubble();
      @(negedge clk);
      if (i < 5) chk("bubble_we", int'(mem_we), 0);
    end
    drain();

    // empty tile: Done the cycle after Start, no writes
    push(1'b0, 10'd0, 8'd0, 1'b1);
    do_start(10'd300, 10'd4, 6'd4, 6'd0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    drain();

    // address wrap at 2^10
    do_start(10'd1020, 10'd6, 6'd1, 6'd6);
    for (int i = 0; i < 6; i++)
      send(8'(8'h40 + i), wrap_addr[i], i == 5);
    bubble();
    drain();

    // Start re-pulsed mid-tile must be ignored
    do_start(10'd100, 10'd8, 6'd2, 6'd3);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h60 + i), t1_addr[i], i == 5);
      #1;
      if (i == 1) begin start = 1'b1; base = 10'd500; end
      if (i == 2) start = 1'b0;
    end
    bubble();
    drain();

    // reset mid-tile, then a full fresh tile
    do_start(10'd200, 10'd10, 6'd2, 6'd2);
    send(8'h80, 10'd200, 1'b0);
    send(8'h81, 10'd201, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_we", int'(mem_we), 0);
    chk("clr_addr", int'(mem_addr), 0);
    chk("clr_data", int'(mem_data), 0);
    chk("clr_ready", int'(in_ready), 0);
    chk("clr_busy", int'(busy), 0);
    chk("clr_left", q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(10'd200, 10'd10, 6'd2, 6'd2);
    send(8'h90, 10'd200, 1'b0);
    send(8'h91, 10'd201, 1'b0);
    send(8'h92, 10'd210, 1'b0);
    send(8'h93, 10'd211, 1'b1);
    bubble();
    drain();
    chk("final_busy", int'(busy), 0);
    chk("final_ready", int'(in_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
